mult8_seq_ctrl: RTL and testbench
=================================

MULT8_SEQ_CTRL -- requirements
Module: mult8_seq_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of completed-operation counter.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  in  1  operand pair offered.
REQ-005 SHALL have port: in_ready  out  1  block accepts operands this cycle.
REQ-006 SHALL have port: A  in  8  multiplicand.
REQ-007 SHALL have port: B  in  8  multiplier.
REQ-008 SHALL have port: mode  in  1  0 = exact add combine, 1 = OR combine (approximate).
REQ-009 SHALL have port: out_valid  out  1  result R valid.
REQ-010 SHALL have port: out_ready  in  1  consumer takes R.
REQ-011 SHALL have port: R  out  16  product.
REQ-012 SHALL have port: busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port: op_cnt  out  CNT_W  count of completed output handshakes.

Function
REQ-014 SHALL time-share one internal exact 4x4 unsigned multiplier (8-bit product) across four steps per operation.
REQ-015 SHALL have states IDLE, STEP0..STEP3 and DONE.
REQ-016 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready).
REQ-017 SHALL latch A, B and mode, clear the accumulator, and enter STEP0 on any edge where in_valid & in_ready.
REQ-018 SHALL compute, in order STEP0..STEP3: LL=A[3:0]*B[3:0], LH=A[3:0]*B[7:4], HL=A[7:4]*B[3:0], HH=A[7:4]*B[7:4].
REQ-019 SHALL align the partial products as LL<<0, LH<<4, HL<<4, HH<<8 in 16 bits.
REQ-020 SHALL, with mode=0, add each aligned term into the 16-bit accumulator; the final value equals A*B exactly and never overflows.
REQ-021 SHALL, with mode=1, bitwise-OR each aligned term into the accumulator with no carry.
REQ-022 SHALL advance one step per clock, enter DONE at the edge that completes STEP3, and assert out_valid only in DONE (accept edge t -> out_valid high after edge t+4).
REQ-023 SHALL hold R and out_valid stable in DONE while out_ready=0.
REQ-024 SHALL, on out_valid & out_ready, increment op_cnt (wrapping modulo 2^CNT_W) and go to STEP0 if in_valid is also high, else to IDLE.
REQ-025 SHALL ignore in_valid in STEP0..STEP3; operand and mode changes during an operation SHALL NOT affect it.
REQ-026 SHALL keep R equal to the accumulator; R is don't-care while out_valid=0 but deterministic.
REQ-027 SHALL sustain one operation per 5 cycles under continuous in_valid and out_ready.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force state=IDLE, out_valid=0, busy=0, R=0, op_cnt=0 and the latched operands and mode to 0; in_ready then reads 1.
REQ-029 SHALL abandon any in-flight or undelivered result when reset asserts mid-operation, with no output handshake and no op_cnt increment.
REQ-030 SHALL accept its first operands on the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL pass: mode=0, A=0x12, B=0x34 -> R=0x03A8, out_valid exactly 4 edges after accept.
REQ-032 SHALL pass: mode=1, A=0x12, B=0x34 -> R=0x0368; mode=1, A=B=0xFF -> R=0xEFF1; mode=0, A=B=0xFF -> R=0xFE01.
REQ-033 SHALL pass: out_ready held low for 10 cycles in DONE -> R and out_valid stable, in_ready=0, op_cnt unchanged; out_ready high -> op_cnt+1.
REQ-034 SHALL pass: back-to-back ops with in_valid and out_ready constantly high -> new accept on the same edge as each output handshake, period 5 cycles.
REQ-035 SHALL pass: A, B and mode toggled during STEP1 -> result matches the originally latched values.
REQ-036 SHALL pass: rst_n pulsed low during STEP2 -> immediate IDLE, out_valid=0, op_cnt=0; next op correct.

Source files
------------

// File: rtl/mult8_seq_ctrl.sv
// rtl/mult8_seq_ctrl.sv - 8x8 multiplier built from one shared 4x4 multiplier over four steps
// Handshaked input/output; mode selects exact add or carry-free OR combining of partial products.
module mult8_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      R,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP0 = 3'd1,
    STEP1 = 3'd2,
    STEP2 = 3'd3,
    STEP3 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic             r_mode;
  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_take;
  logic             w_step;
  logic [3:0]       w_x;
  logic [3:0]       w_y;
  logic [7:0]       w_pp;
  logic [15:0]      w_term;

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign R         = r_acc;
  assign op_cnt    = r_cnt;

  assign w_accept = in_valid & in_ready;
  assign w_take   = out_valid & out_ready;
  assign w_step   = (r_state == STEP0) | (r_state == STEP1) |
                    (r_state == STEP2) | (r_state == STEP3);

  // Nibble selection: step order LL, LH, HL, HH.
  always_comb begin
    w_x    = r_a[3:0];
    w_y    = r_b[3:0];
    w_term = 16'd0;
    case (r_state)
      STEP0: begin
        w_x = r_a[3:0];
        w_y = r_b[3:0];
      end
      STEP1: begin
        w_x = r_a[3:0];
        w_y = r_b[7:4];
      end
      STEP2: begin
        w_x = r_a[7:4];
        w_y = r_b[3:0];
      end
      STEP3: begin
        w_x = r_a[7:4];
        w_y = r_b[7:4];
      end
      default: ;
    endcase
    case (r_state)
      STEP0:        w_term = {8'd0, w_pp};
      STEP1, STEP2: w_term = {4'd0, w_pp, 4'd0};
      STEP3:        w_term = {w_pp, 8'd0};
      default:      w_term = 16'd0;
    endcase
  end

  assign w_pp = {4'd0, w_x} * {4'd0, w_y};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = STEP0;
      STEP0:   w_next = STEP1;
      STEP1:   w_next = STEP2;
      STEP2:   w_next = STEP3;
      STEP3:   w_next = DONE;
      DONE:    if (w_take) w_next = in_valid ? STEP0 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= 8'd0;
      r_b    <= 8'd0;
      r_mode <= 1'b0;
      r_acc  <= 16'd0;
      r_cnt  <= '0;
    end else begin
      if (w_take) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_accept) begin
        r_a    <= A;
        r_b    <= B;
        r_mode <= mode;
        r_acc  <= 16'd0;
      end else if (w_step) begin
        r_acc <= r_mode ? (r_acc | w_term) : (r_acc + w_term);
      end
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb/tb_mult8_seq_ctrl.sv - directed self-checking bench for mult8_seq_ctrl
module tb_mult8_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] R;
  logic        busy;
  logic [15:0] op_cnt;

  int total;
  int bad;
  int exp_cnt;

  mult8_seq_ctrl #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .R        (R),
    .busy     (busy),
    .op_cnt   (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Caller must be at a negedge; returns at a negedge with the block back in IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                        input logic [15:0] exp, input int stall, input bit tog,
                        input string tag);
    int lat;
    A = a; B = b; mode = m; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (tog && lat == 1) begin
        A = ~a; B = ~b; mode = ~m;
      end
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_R"}, R, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_R"}, R, exp);
      chk({tag, "_stall_in_ready"}, in_ready, 0);
      chk({tag, "_stall_cnt"}, op_cnt, exp_cnt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt++;
    chk({tag, "_cnt"}, op_cnt, exp_cnt);
    chk({tag, "_valid_clr"}, out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int cyc;
    int prev;
    int guard;
    int lat;
    total = 0; bad = 0; exp_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = 8'd0; B = 8'd0; mode = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_R", R, 16'h0000);
    chk("rst_cnt", op_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h12, 8'h34, 1'b0, 16'h03A8, 0, 1'b0, "add_12x34");
    @(negedge clk);
    run_op(8'h12, 8'h34, 1'b1, 16'h0368, 0, 1'b0, "or_12x34");
    run_op(8'hFF, 8'hFF, 1'b1, 16'hEFF1, 0, 1'b0, "or_FFxFF");
    run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b0, "add_FFxFF");
    run_op(8'h0A, 8'h0B, 1'b0, 16'h006E, 10, 1'b0, "stall");
    run_op(8'h5C, 8'h37, 1'b0, 16'h13C4, 0, 1'b1, "toggle");

    // Back-to-back with both handshakes held high: one result every 5 cycles.
    A = 8'h03; B = 8'h07; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; prev = 0;
    for (int i = 0; i < 3; i++) begin
      guard = 0;
      while (!out_valid && guard < 20) begin
        @(negedge clk);
        cyc++; guard++;
      end
      chk("b2b_R", R, 16'h0015);
      chk("b2b_in_ready", in_ready, 1);
      if (i > 0) chk("b2b_period", cyc - prev, 5);
      prev = cyc;
      if (i == 2) in_valid = 1'b0;
      @(negedge clk);
      cyc++;
      exp_cnt++;
      chk("b2b_cnt", op_cnt, exp_cnt);
      chk("b2b_busy", busy, (i < 2) ? 1 : 0);
    end
    out_ready = 1'b0;

    // Reset pulse while the operation sits in STEP2.
    @(negedge clk);
    A = 8'h44; B = 8'h55; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (lat < 2) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", op_cnt, 0);
    chk("mid_rst_R", R, 16'h0000);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    chk("mid_rst_hold_valid", out_valid, 0);
    rst_n = 1'b1;
    run_op(8'h81, 8'h02, 1'b0, 16'h0102, 0, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
